// File: rtl/vm_pkg.sv
// vm_pkg: shared state encoding, coin codes and credit-accumulator ops for vending_machine_credit.
package vm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} vm_state_t;
  typedef enum logic [2:0] {ACC_HOLD, ACC_ADD, ACC_VEND, ACC_DEC, ACC_CLR} acc_op_t;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1 = 2'b01;
  localparam logic [1:0] COIN_2 = 2'b10;
  localparam logic [1:0] COIN_CANCEL = 2'b11;
  function automatic logic is_coin(input logic [1:0] c);
    return c == COIN_1 || c == COIN_2;
  endfunction
endpackage

// File: rtl/vm_credit_acc.sv
// vm_credit_acc: credit register with add-coin, subtract-price, decrement and clear operations.
module vm_credit_acc
  import vm_pkg::*;
#(
  parameter int CREDIT_W  = 4,
  parameter int PRICE     = 3,
  parameter int COIN1_VAL = 1,
  parameter int COIN2_VAL = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          i_coin,
  input  acc_op_t             i_op,
  output logic [CREDIT_W:0]   o_sum,
  output logic [CREDIT_W-1:0] o_credit
);
  localparam logic [CREDIT_W-1:0] C1 = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] C2 = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] PR = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE = CREDIT_W'(1);
  logic [CREDIT_W-1:0] r_credit, w_val, w_next;
  assign w_val = i_coin == COIN_1 ? C1 : i_coin == COIN_2 ? C2 : '0;
  assign o_sum = {1'b0, r_credit} + {1'b0, w_val};
  assign o_credit = r_credit;
  always_comb begin
    w_next = i_op == ACC_ADD  ? o_sum[CREDIT_W-1:0] :
             i_op == ACC_VEND ? r_credit - PR :
             i_op == ACC_DEC  ? r_credit - ONE :
             i_op == ACC_CLR  ? '0 : r_credit;
  end
  always_ff @(posedge clk) begin
    if (!reset) r_credit <= '0;
    else r_credit <= w_next;
  end
endmodule

// File: rtl/vending_machine_credit.sv
// vending_machine_credit: coin-credit vending FSM; define VM_CHANGE_EN to return overpay and
// allow cancel-refund through the CHANGE state, otherwise overpay is forfeited.
module vending_machine_credit
  import vm_pkg::*;
#(
  parameter int CREDIT_W  = 4,
  parameter int PRICE     = 3,
  parameter int COIN1_VAL = 1,
  parameter int COIN2_VAL = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                vend_ack,
  output logic                vend_valid,
  output logic                change_valid,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);
  localparam int MAX_COIN = COIN1_VAL > COIN2_VAL ? COIN1_VAL : COIN2_VAL;
  localparam logic [CREDIT_W-1:0] ONE = CREDIT_W'(1);
  if (PRICE == 0 || PRICE - 1 + MAX_COIN > 2**CREDIT_W - 1) begin : g_bad_cfg
    $error("vending_machine_credit: PRICE/coin values do not fit CREDIT_W");
  end
  vm_state_t r_state, w_next;
  acc_op_t w_op;
  logic [CREDIT_W:0] w_sum;
  logic w_paid, r_coin_reject;
  vm_credit_acc #(
    .CREDIT_W(CREDIT_W), .PRICE(PRICE), .COIN1_VAL(COIN1_VAL), .COIN2_VAL(COIN2_VAL)
  ) u_acc (
    .clk(clk), .reset(reset), .i_coin(coin), .i_op(w_op), .o_sum(w_sum), .o_credit(credit)
  );
  assign w_paid = w_sum >= (CREDIT_W+1)'(PRICE);
`ifdef VM_CHANGE_EN
  logic w_over;
  assign w_over = credit > CREDIT_W'(PRICE);
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_coin_reject <= 1'b0;
    end else begin
      r_state <= w_next;
      r_coin_reject <= (r_state == VEND || r_state == CHANGE) && is_coin(coin);
    end
  end
  // a coin that reaches PRICE vends on the same edge, even straight from IDLE
  always_comb begin
    w_next = r_state;
    w_op = ACC_HOLD;
    case (r_state)
      IDLE, COLLECT:
        if (is_coin(coin)) begin
          w_op = ACC_ADD;
          w_next = w_paid ? VEND : COLLECT;
        end
`ifdef VM_CHANGE_EN
        else if (coin == COIN_CANCEL && r_state == COLLECT) w_next = CHANGE;
`endif
      VEND:
        if (vend_ack) begin
`ifdef VM_CHANGE_EN
          w_op = w_over ? ACC_VEND : ACC_CLR;
          w_next = w_over ? CHANGE : IDLE;
`else
          w_op = ACC_CLR;
          w_next = IDLE;
`endif
        end
      CHANGE: begin
        w_op = ACC_DEC;
        w_next = credit <= ONE ? IDLE : CHANGE;
      end
      default: ;
    endcase
  end
  always_comb begin
    vend_valid = r_state == VEND;
`ifdef VM_CHANGE_EN
    change_valid = r_state == CHANGE;
`else
    change_valid = 1'b0;
`endif
  end
  assign coin_reject = r_coin_reject;
  assign state = r_state;
endmodule

// File: doc/vending_machine_credit.md
VENDING_MACHINE_CREDIT -- requirements
Module: vending_machine_credit

Interface
REQ-001 SHALL have parameter CREDIT_W, default 4, credit register width.
REQ-002 SHALL have parameter PRICE, default 3, item price in credit units.
REQ-003 SHALL have parameter COIN1_VAL, default 1, credit value of coin code 01.
REQ-004 SHALL have parameter COIN2_VAL, default 2, credit value of coin code 10.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port coin  input  2  per-cycle code: 00 none, 01 COIN1, 10 COIN2, 11 cancel.
REQ-008 SHALL have port vend_ack  input  1  dispenser accepted the item.
REQ-009 SHALL have port vend_valid  output  1  item dispense request.
REQ-010 SHALL have port change_valid  output  1  one credit unit returned this cycle.
REQ-011 SHALL have port coin_reject  output  1  one-cycle pulse; coin arrived while not accepting.
REQ-012 SHALL have port credit  output  CREDIT_W  current credit.
REQ-013 SHALL have port state  output  2  current state (IDLE=0, COLLECT=1, VEND=2, CHANGE=3).

Function
REQ-014 SHALL treat PRICE-1+max(COIN1_VAL,COIN2_VAL) > 2^CREDIT_W-1, or PRICE=0, as illegal configuration (elaboration-time assertion).
REQ-015 SHALL, in IDLE, add the coin value to credit and go to COLLECT on code 01/10; code 11 ignored.
REQ-016 SHALL, in COLLECT, add the coin value each cycle; go to VEND the same edge credit+value >= PRICE, registering the full sum.
REQ-017 SHALL drive vend_valid=1 exactly while state=VEND, holding it until vend_ack is sampled high.
REQ-018 SHALL, on vend_ack in VEND, set credit to credit-PRICE and go to CHANGE if result >0 (VM_CHANGE_EN defined), else clear credit and go to IDLE.
REQ-019 SHALL ignore vend_ack outside VEND.
REQ-020 SHALL, in CHANGE, assert change_valid every cycle and decrement credit by 1 per cycle; go to IDLE on the edge credit reaches 0 (N units take N cycles).
REQ-021 SHALL reject coin codes 01/10 in VEND or CHANGE: credit unchanged, coin_reject high the following cycle for one cycle; code 11 there is ignored.
REQ-022 SHALL derive vend_valid, change_valid from state only (Moore); coin_reject registered.

Reset
REQ-023 SHALL, with reset low at a clock edge, set state=IDLE, credit=0, vend_valid=0, change_valid=0, coin_reject=0, overriding all other inputs.
REQ-024 SHALL discard credit on reset mid-operation; no change is returned.

Configuration
REQ-025 SHALL use macro VM_CHANGE_EN: defined -> overpay returned via CHANGE (REQ-018/020) and cancel (11) in COLLECT goes to CHANGE refunding full credit.
REQ-026 SHALL, without VM_CHANGE_EN, never enter CHANGE: overpay forfeited (credit cleared on vend_ack), cancel in COLLECT ignored, change_valid tied 0.

Structure
REQ-027 SHALL take state encoding and coin code constants from shared package vm_pkg.
REQ-028 SHALL place credit add/subtract/decrement logic in sub-module vm_credit_acc; FSM stays in top level.

Verification (PRICE=3, COIN1_VAL=1, COIN2_VAL=2, VM_CHANGE_EN defined unless stated)
REQ-029 SHALL cover: coin 01,01,01 -> credit 1,2,3, vend_valid high after third edge; ack -> IDLE, credit 0, no change_valid.
REQ-030 SHALL cover: coin 10,10 -> credit 4, VEND; ack -> one change_valid cycle, credit 0, IDLE.
REQ-031 SHALL cover: coin 10 then 11 -> CHANGE, two change_valid cycles, vend_valid never high, IDLE.
REQ-032 SHALL cover: coin 01 while VEND with vend_ack low for 5 cycles -> coin_reject one pulse, credit stays 3, vend_valid held.
REQ-033 SHALL cover: reset low during CHANGE with credit 2 -> next edge all outputs 0, state IDLE.
REQ-034 SHALL cover: VM_CHANGE_EN undefined, coin 10,10, ack -> IDLE, credit 0, change_valid never high; 01 then 11 -> stays COLLECT, credit 1.
